// File: rtl/pe_mac_sequencer.sv
// pe_mac_sequencer: drives one FP MAC PE through a full dot product (load B, clear, stream A).
// Define PE_SEQ_TIMEOUT_EN to add the WAIT-state watchdog and the sticky err flag.
module pe_mac_sequencer #(
  parameter int L_RAM_SIZE = 6,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [L_RAM_SIZE:0]   len,
  output logic                  busy,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [31:0]           ld_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [31:0]           a_data,
  output logic                  pe_aresetn,
  output logic [31:0]           pe_din,
  output logic [L_RAM_SIZE-1:0] pe_addr,
  output logic                  pe_we,
  output logic [31:0]           pe_ain,
  output logic                  pe_valid,
  input  logic                  pe_dvalid,
  input  logic [31:0]           pe_dout,
  output logic [31:0]           result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  err
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] CLR   = 3'd2;
  localparam logic [2:0] FETCH = 3'd3;
  localparam logic [2:0] ISSUE = 3'd4;
  localparam logic [2:0] WAIT  = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;
  localparam int CW = $clog2(CLR_CYCLES);
  localparam logic [L_RAM_SIZE:0] NMAX = {1'b1, {L_RAM_SIZE{1'b0}}};

  logic [2:0]            state;
  logic [L_RAM_SIZE-1:0] idx;
  logic [L_RAM_SIZE:0]   n;
  logic [CW-1:0]         clr_cnt;
  logic [31:0]           res_q;
  logic                  last;
  logic                  timeout;

  assign last         = {1'b0, idx} == n - (L_RAM_SIZE+1)'(1);
  assign busy         = state != IDLE;
  assign ld_ready     = state == LOAD;
  assign a_ready      = state == ISSUE;
  assign pe_aresetn   = state != CLR;
  assign pe_we        = ld_ready && ld_valid;
  assign pe_din       = pe_we ? ld_data : '0;
  assign pe_addr      = idx;
  assign pe_valid     = a_ready && a_valid;
  assign pe_ain       = pe_valid ? a_data : '0;
  assign result       = res_q;
  assign result_valid = state == DONE;

`ifdef PE_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] to_cnt;
  logic          err_q;
  assign timeout = state == WAIT && !pe_dvalid && to_cnt == TW'(TIMEOUT-1);
  assign err     = err_q;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      to_cnt <= (state == WAIT && !pe_dvalid) ? to_cnt + TW'(1) : '0;
      if (timeout) err_q <= 1'b1;
    end
`else
  assign timeout = 1'b0;
  assign err     = TIMEOUT < 0;
`endif

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state   <= IDLE;
      idx     <= '0;
      n       <= '0;
      clr_cnt <= '0;
      res_q   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          n   <= len > NMAX ? NMAX : len;
          idx <= '0;
          if (len == '0) begin
            res_q <= '0;
            state <= DONE;
          end else state <= LOAD;
        end
        LOAD: if (ld_valid) begin
          idx <= last ? '0 : idx + L_RAM_SIZE'(1);
          if (last) state <= CLR;
        end
        CLR: begin
          clr_cnt <= clr_cnt + CW'(1);
          if (clr_cnt == CW'(CLR_CYCLES-1)) begin
            clr_cnt <= '0;
            state   <= FETCH;
          end
        end
        FETCH: state <= ISSUE;
        ISSUE: if (a_valid) state <= WAIT;
        WAIT: if (timeout) begin
          res_q <= 32'hFFFF_FFFF;
          idx   <= '0;
          state <= DONE;
        end else if (pe_dvalid) begin
          // accumulator is not pipelined: only the final element's sum is kept
          if (last) begin
            res_q <= pe_dout;
            idx   <= '0;
            state <= DONE;
          end else begin
            idx   <= idx + L_RAM_SIZE'(1);
            state <= FETCH;
          end
        end
        DONE: if (result_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pe_mac_sequencer.sv
// tb_pe_mac_sequencer: vector table of dot-product jobs against a behavioural FP MAC PE.
module tb_pe_mac_sequencer;
  localparam int PE_LAT = 3;

  typedef struct packed {
    logic [6:0]       len;
    logic [3:0][31:0] b;
    logic [3:0][31:0] a;
    logic [7:0]       stall;
    logic [31:0]      exp;
  } vec_t;

  logic        aclk = 1'b0;
  logic        aresetn, start, busy, ld_valid, ld_ready, a_valid, a_ready;
  logic [6:0]  len;
  logic [31:0] ld_data, a_data, pe_din, pe_ain, pe_dout, result;
  logic [5:0]  pe_addr;
  logic        pe_aresetn, pe_we, pe_valid, pe_dvalid, result_valid, result_ready, err;

  int total = 0;
  int bad = 0;

  always #5 aclk = ~aclk;

  pe_mac_sequencer dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .len(len), .busy(busy),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .pe_aresetn(pe_aresetn), .pe_din(pe_din), .pe_addr(pe_addr), .pe_we(pe_we),
    .pe_ain(pe_ain), .pe_valid(pe_valid), .pe_dvalid(pe_dvalid), .pe_dout(pe_dout),
    .result(result), .result_valid(result_valid), .result_ready(result_ready), .err(err)
  );

  function automatic real f2r(input logic [31:0] b);
    real v;
    if (b[30:23] == 8'd0) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    for (int i = 127; i < int'(b[30:23]); i++) v = v * 2.0;
    for (int i = int'(b[30:23]); i < 127; i++) v = v / 2.0;
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real x);
    real v;
    int e;
    logic s;
    s = x < 0.0;
    v = s ? -x : x;
    if (v == 0.0) return 32'h0;
    e = 127;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0) begin v = v * 2.0; e--; end
    return {s, 8'(e), 23'($rtoi((v - 1.0) * 8388608.0))};
  endfunction

  // behavioural PE: registered RAM read, non-pipelined accumulator, 2-cycle dvalid
  logic [31:0] ram [0:63];
  logic [31:0] ram_q;
  real         acc = 0.0;
  int          dv_cnt = 0;
  bit          pe_dead = 1'b0;

  always @(posedge aclk) begin
    if (pe_we) ram[pe_addr] <= pe_din;
    ram_q <= ram[pe_addr];
    if (dv_cnt > 0) dv_cnt <= dv_cnt - 1;
    if (!pe_aresetn) acc <= 0.0;
    else if (pe_valid) begin
      acc     <= acc + f2r(ram_q) * f2r(pe_ain);
      pe_dout <= r2f(acc + f2r(ram_q) * f2r(pe_ain));
      dv_cnt  <= PE_LAT + 1;
    end
  end
  assign pe_dvalid = !pe_dead && (dv_cnt == 1 || dv_cnt == 2);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [31:0] b0, b1, b2, b3,
                              input logic [31:0] a0, a1, a2, a3, input int st, input logic [31:0] e);
    vec_t v;
    v.len = 7'(n);
    v.b = {b3, b2, b1, b0};
    v.a = {a3, a2, a1, a0};
    v.stall = 8'(st);
    v.exp = e;
    return v;
  endfunction

  task automatic run_job(input vec_t v, input int budget, output logic [31:0] res, output int pv,
                         output int we, output int lat, output int viol, output bit done);
    int li, ai, ast;
    li = 0; ai = 0; ast = 0; pv = 0; we = 0; lat = 0; viol = 0; done = 1'b0; res = '0;
    @(negedge aclk);
    start = 1'b1;
    len = v.len;
    @(negedge aclk);
    start = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      ld_valid = (li < int'(v.len)) && (v.stall == 0 || c % 3 != 0);
      ld_data = v.b[li % 4];
      if (a_ready && ast < int'(v.stall)) begin
        a_valid = 1'b0;
        ast++;
      end else a_valid = ai < int'(v.len);
      a_data = v.a[ai % 4];
      #1;
      if (pe_valid !== (a_valid && a_ready)) viol++;
      if (pe_we && (pe_addr != li[5:0] || pe_din != ld_data)) viol++;
      if (pe_we) we++;
      if (pe_valid) pv++;
      if (ld_valid && ld_ready) li++;
      if (a_valid && a_ready) begin ai++; ast = 0; end
      if (result_valid) begin
        res = result;
        result_ready = 1'b1;
        done = 1'b1;
        lat = c;
      end
      @(negedge aclk);
    end
    ld_valid = 1'b0;
    a_valid = 1'b0;
    result_ready = 1'b0;
  endtask

  vec_t        tv [6];
  logic [31:0] res;
  int          pv, we, lat, viol;
  bit          done;

  initial begin
    tv[0] = mk(2, 32'h3F800000, 32'h40000000, 0, 0, 32'h40400000, 32'h40800000, 0, 0, 0, 32'h41300000);
    tv[1] = mk(1, 32'h40000000, 0, 0, 0, 32'h40000000, 0, 0, 0, 0, 32'h40800000);
    tv[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    tv[3] = mk(2, 32'h3F800000, 32'h40000000, 0, 0, 32'h40400000, 32'h40800000, 0, 0, 10, 32'h41300000);
    tv[4] = mk(3, 32'h3F800000, 32'h3F800000, 32'h3F800000, 0,
               32'h3F800000, 32'h40000000, 32'h40400000, 0, 0, 32'h40C00000);
    tv[5] = mk(4, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000,
               32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 2, 32'h41000000);

    aresetn = 1'b0; start = 1'b0; len = '0; ld_valid = 1'b0; ld_data = '0;
    a_valid = 1'b0; a_data = '0; result_ready = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    chk("rst_busy", busy, 0);
    chk("rst_pe_aresetn", pe_aresetn, 1);
    chk("rst_result", result, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_pe_we", pe_we, 0);
    chk("rst_pe_valid", pe_valid, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_pe_addr", pe_addr, 0);
    chk("rst_err", err, 0);
    aresetn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_job(tv[i], 2000, res, pv, we, lat, viol, done);
      chk($sformatf("job%0d_done", i), done, 1);
      chk($sformatf("job%0d_result", i), res, tv[i].exp);
      chk($sformatf("job%0d_pe_valid_count", i), pv, tv[i].len);
      chk($sformatf("job%0d_pe_we_count", i), we, tv[i].len);
      chk($sformatf("job%0d_protocol", i), viol, 0);
      chk($sformatf("job%0d_rv_after", i), result_valid, 0);
      chk($sformatf("job%0d_busy_after", i), busy, 0);
      if (tv[i].len == 0) chk($sformatf("job%0d_latency", i), lat, 0);
    end

    // drop reset while the first element is in flight in WAIT
    run_job(tv[0], 7, res, pv, we, lat, viol, done);
    chk("midwait_issued", pv, 1);
    chk("midwait_busy", busy, 1);
    chk("midwait_a_ready", a_ready, 0);
    aresetn = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_result", result, 0);
    chk("midrst_pe_aresetn", pe_aresetn, 1);
    chk("midrst_pe_addr", pe_addr, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    run_job(tv[0], 2000, res, pv, we, lat, viol, done);
    chk("postrst_done", done, 1);
    chk("postrst_result", res, 32'h41300000);

    pe_dead = 1'b1;
    run_job(tv[1], 200, res, pv, we, lat, viol, done);
`ifdef PE_SEQ_TIMEOUT_EN
    chk("timeout_done", done, 1);
    chk("timeout_result", res, 32'hFFFFFFFF);
    chk("timeout_err", err, 1);
`else
    chk("notimeout_done", done, 0);
    chk("notimeout_busy", busy, 1);
    chk("notimeout_err", err, 0);
`endif
    pe_dead = 1'b0;
    aresetn = 1'b0;
    @(negedge aclk);
    chk("final_rst_err", err, 0);
    chk("final_rst_busy", busy, 0);
    aresetn = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pe_mac_sequencer.md
Name: pe_mac_sequencer

Overview:
- Controller that sequences one single-precision MAC processing element (PE) through a complete dot product.
- Loads a vector into the PE local RAM, then pulses the PE's reset to clear its accumulator.
- Streams the second vector into the PE one element at a time, waiting for each MAC result before issuing the next, because the accumulator feedback is not pipelined.
- Sits between the AXI-stream-style host buffers and the PE. Returns the final sum through a valid/ready result port.

Parameters:
L_RAM_SIZE, 6, PE local RAM address width; maximum vector length is 2**L_RAM_SIZE.
CLR_CYCLES, 2, number of cycles pe_aresetn is held low to clear the PE accumulator (minimum 2, required by the FP IP).
TIMEOUT, 64, WAIT-state watchdog limit in cycles (used only with the optional feature).

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
start  in  1  begin a job; sampled only in IDLE
len  in  L_RAM_SIZE+1  vector length; sampled at start
busy  out  1  high in every state except IDLE
ld_valid / ld_ready / ld_data  in / out / in  1 / 1 / 32  B-vector load stream
a_valid / a_ready / a_data  in / out / in  1 / 1 / 32  A-vector operand stream
pe_aresetn  out  1  PE reset, active-low
pe_din  out  32  PE RAM write data
pe_addr  out  L_RAM_SIZE  PE RAM address
pe_we  out  1  PE RAM write enable
pe_ain  out  32  PE port-A operand
pe_valid  out  1  PE input valid (one-cycle pulse)
pe_dvalid  in  1  PE result valid
pe_dout  in  32  PE result
result  out  32  final dot product
result_valid / result_ready  out / in  1 / 1  result handshake
err  out  1  timeout flag (optional feature)

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE and idx to 0.
  - pe_aresetn=1. All other outputs, including result, are 0.
- States: IDLE, LOAD, CLR, FETCH, ISSUE, WAIT, DONE.
- IDLE:
  - start=1 latches len into n, clamped to 2**L_RAM_SIZE.
  - len=0 goes straight to DONE with result=0. Otherwise go to LOAD with idx=0.
- LOAD:
  - ld_ready=1.
  - Each cycle with ld_valid=1 drives pe_we=1, pe_addr=idx, pe_din=ld_data, then increments idx.
  - After the transfer with idx=n-1: go to CLR and reset idx to 0.
- CLR:
  - pe_aresetn=0 for exactly CLR_CYCLES cycles, then go to FETCH.
- FETCH:
  - Drives pe_addr=idx with pe_we=0 for one cycle so the PE's registered RAM read completes. Then go to ISSUE.
- ISSUE:
  - pe_addr is held. a_ready=1.
  - On a_valid=1: pe_valid=1 and pe_ain=a_data for exactly one cycle, then go to WAIT.
  - a_valid=0 stalls in ISSUE.
- WAIT:
  - pe_valid=0. The first pe_dvalid=1 captures pe_dout into an internal register.
  - If idx=n-1: go to DONE with result=captured value. Otherwise increment idx and go to FETCH.
  - Extra dvalid cycles after the first are ignored.
- DONE:
  - result_valid=1 and result is held stable until result_ready=1, then go to IDLE.
  - result_valid falls the cycle after the handshake.
- busy follows the busy port definition above.
- start asserted outside IDLE is ignored. ld_ready and a_ready are 0 outside LOAD and ISSUE respectively.
- pe_addr wraps naturally; it never exceeds n-1 because n is clamped.
- Per-element latency: 2 cycles + PE latency + ISSUE stall.

Optional Feature:
- Macro PE_SEQ_TIMEOUT_EN.
- With the macro: a counter runs in WAIT. If TIMEOUT cycles pass without pe_dvalid:
  - err is set and sticky until aresetn.
  - result is set to 0xFFFFFFFF and the state goes to DONE.
- Without the macro: WAIT waits indefinitely, err is tied to 0, and no counter is synthesized.

Test Plan:
- len=2, B=[0x3F800000, 0x40000000], A=[0x40400000, 0x40800000] -> result=0x41300000 (11.0); one result_valid pulse until ready; busy low afterwards.
- Two back-to-back jobs, the second with len=1, B=[0x40000000], A=[0x40000000] -> result=0x40800000 (4.0); proves the CLR state removes the previous sum.
- len=0 with start -> DONE on the next cycle, result=0, no pe_we or pe_valid activity.
- a_valid held low 10 cycles in ISSUE, ld_valid gaps in LOAD -> pe_valid never asserted while stalled; final result unchanged (11.0 case).
- aresetn dropped mid-WAIT -> all outputs 0 and IDLE immediately (asynchronous); a new job completes correctly afterwards.
- With PE_SEQ_TIMEOUT_EN, pe_dvalid forced 0 -> err=1 and result=0xFFFFFFFF after 64 cycles in WAIT. Without the macro -> busy stays high and err stays 0.
